// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int          DIV_WIDTH  = 32;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE    = 32'hFFFF_FFFF;
    localparam int          DIV_CYCLES = DIV_WIDTH + 2;

endpackage

// File: rtl/div_addsub.sv
// Combinational add/subtract for the divider accumulator; subtract is a + ~b + 1.
// Zero latency; no flow control.
module div_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum
);

    logic [W-1:0] w_b_eff;

    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign o_sum   = i_a + w_b_eff + {{(W-1){1'b0}}, i_sub};

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider: non-restoring, one quotient bit per cycle, then sign fix-up.
// Ready pulses WIDTH+2 edges after accept (1 for divide-by-zero); start is ignored while busy.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             exception,
    output logic             busy,
    output logic             ready
);

    div_state_t       r_state;
    div_state_t       w_state_nxt;

    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_sign_dvd;
    logic             r_sign_dvs;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_exc;
    logic             r_busy;
    logic             r_ready;

    logic             w_accept;
    logic             w_dvs_zero;
    logic             w_last;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic [WIDTH:0]   w_add_a;
    logic [WIDTH:0]   w_add_b;
    logic             w_add_sub;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_a_fix;
    logic [WIDTH-1:0] w_quot_signed;
    logic [WIDTH-1:0] w_rem_signed;

    // The ready cycle already sits in IDLE, so a start there must be held off.
    assign w_accept   = (r_state == IDLE) && start && !r_ready;
    assign w_dvs_zero = (divisor == '0);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    assign w_dvd_abs  = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_dvs_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;

    // RUN feeds the shifted {A,Q}; FIX feeds A unshifted for the remainder restore.
    assign w_add_a    = (r_state == FIX) ? r_a : {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_add_b    = {1'b0, r_m};
    assign w_add_sub  = (r_state == RUN) && !r_a[WIDTH];

    div_addsub #(
        .W(WIDTH + 1)
    ) u_addsub (
        .i_a  (w_add_a),
        .i_b  (w_add_b),
        .i_sub(w_add_sub),
        .o_sum(w_sum)
    );

    assign w_a_fix       = r_a[WIDTH] ? w_sum : r_a;
    assign w_quot_signed = (r_sign_dvd ^ r_sign_dvs) ? -r_q : r_q;
    assign w_rem_signed  = r_sign_dvd ? -w_a_fix[WIDTH-1:0] : w_a_fix[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_dvs_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = FIX;
                end
            end
            FIX:     w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                    end
                end
                RUN: r_cnt <= r_cnt + 1'b1;
                DONE: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a        <= '0;
            r_q        <= '0;
            r_m        <= '0;
            r_sign_dvd <= 1'b0;
            r_sign_dvs <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && !w_dvs_zero) begin
                        r_a        <= '0;
                        r_q        <= w_dvd_abs;
                        r_m        <= w_dvs_abs;
                        r_sign_dvd <= dividend[WIDTH-1];
                        r_sign_dvs <= divisor[WIDTH-1];
                        r_ovf      <= (dividend == INT_MIN) && (divisor == NEG_ONE);
                    end
                end
                RUN: begin
                    r_a <= w_sum;
                    r_q <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
                end
                FIX:     r_a <= w_a_fix;
                default: ;
            endcase
        end
    end

    // Results are written only at accept (divide-by-zero) or in FIX and then held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_exc  <= 1'b0;
        end else if (r_state == IDLE && w_accept && w_dvs_zero) begin
            r_quot <= '0;
            r_rem  <= dividend;
            r_exc  <= 1'b1;
        end else if (r_state == FIX) begin
            if (r_ovf) begin
                r_quot <= INT_MIN;
                r_rem  <= '0;
                r_exc  <= 1'b1;
            end else begin
                r_quot <= w_quot_signed;
                r_rem  <= w_rem_signed;
                r_exc  <= 1'b0;
            end
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign exception = r_exc;
    assign busy      = r_busy;
    assign ready     = r_ready;

endmodule
